broadcast_alu_slice: RTL and testbench
======================================

Name: broadcast_alu_slice

Overview:
- Bit-serial ALU slice that consumes the 8-bit truth-table vectors broadcast by the vector cycler, the stage directly upstream.
- Operands are processed LSB-first, one bit per matching vector: when the vector's input columns equal the slice's current operand bits, the slice captures the output column it needs.
- Many slices share one broadcast bus. Each slice completes a WIDTH-bit operation in WIDTH..4*WIDTH cycles.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- vector  in  8  broadcast vector, fields MSB..LSB: A, B, X, carry1/OR, sum1/EQ, sum0/XOR, carry0/AND, LT.
- vec_valid  in  1  vector is meaningful this cycle; low during cycler warm-up.
- start  in  1  request; sampled only when ready=1.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SEQ.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- ready  out  1  slice idle; accepts start.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  operation result; held until the next accepted start.
- carry_out  out  1  final carry (ADD/SUB); 0 for other ops.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - ready=1, done=0, result=0, carry_out=0.
  - All internal registers clear.
  - Reset in the middle of an operation aborts it; no done pulse is produced.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - When start=1, capture a, b and op; set index=0, carry=(op==SUB), lt=0, eq=1; go to RUN.
  - The accept cycle performs no bit matching.
- RUN:
  - ready=0. start is ignored.
  - Current bit pair: ai=a[index]; bi=b[index], inverted for SUB.
  - For SLT at index==WIDTH-1 only, the pair is swapped: match A=b[MSB], B=a[MSB].
  - A match occurs when vec_valid=1 and vector[7:6] equals the pair. On a cycle with no match, nothing changes.
- On a match:
  - ADD/SUB:
    - res bit = carry ? sum1 : sum0.
    - carry <= carry ? carry1 : carry0.
  - AND/OR/XOR: res bit = carry0 / carry1 / sum0 respectively.
  - SLT/SLTU: lt <= EQ ? lt : LT.
  - SEQ: eq <= eq & EQ.
  - In all cases, the res bit is written at position index, then index increments.
  - On the match at index==WIDTH-1, go to DONE. For SLT/SLTU/SEQ, result = {0.., lt or eq}.
- DONE:
  - done=1 for exactly one cycle; ready=0; then go to IDLE.
  - result and carry_out update on entry to DONE and hold through IDLE until the next start.
- Register rules:
  - The X field is ignored.
  - vector is used combinationally for the match; all outputs are registered.
- Latency:
  - Start to done is 2 + (number of matched-bit cycles).
  - With a fully cycling bus and vec_valid=1 throughout, this is between WIDTH+2 and 4*WIDTH+2 cycles.
- Boundaries:
  - vec_valid low stalls the operation indefinitely without corrupting state.
  - The index never exceeds WIDTH-1.
  - SUB/ADD carries wrap modulo 2^WIDTH; carry_out holds the final carry (for SUB, 1 = no borrow).
  - A start asserted in the same cycle as done is ignored, because ready=0 during DONE.
  - A start held high during RUN is ignored; it is accepted on the first IDLE cycle.

Test Plan (WIDTH=8; bench drives the cycling sequence rows 00,01,10,11 repeatedly, vec_valid=1 unless stated):
- ADD a=0xFF, b=0x01 -> result 0x00, carry_out 1, single done pulse, latency <= 34 cycles.
- SUB a=0x05, b=0x07 -> result 0xFE, carry_out 0. Then SUB a=0x07, b=0x05 -> 0x02, carry_out 1.
- Logic ops on a=0xA5, b=0x3C:
  - AND -> 0x24.
  - OR -> 0xBD.
  - XOR -> 0x99.
  - carry_out 0 for each.
- Compares:
  - SLTU a=0x80, b=0x01 -> 0x00.
  - SLT a=0x80, b=0x01 -> 0x01.
  - SEQ a=0x5A, b=0x5A -> 0x01.
  - SEQ a=0x5A, b=0x5B -> 0x00.
- Stall and busy: hold vec_valid=0 for 20 cycles mid-ADD (0x12+0x34), and pulse start with other operands during RUN -> result 0x46, stray start ignored, ready stays 0 until DONE passes.
- Mid-operation reset: assert reset low during RUN -> ready=1, result=0, no done pulse. A fresh ADD 0x01+0x01 afterwards -> 0x02.

Source files
------------

// File: rtl/broadcast_alu_slice.sv
`default_nettype none
// ============================================================================
// Module   : broadcast_alu_slice
// Brief    : Bit-serial ALU slice fed by a broadcast truth-table vector bus.
// Revision : 1.0 - initial release
// ============================================================================
module broadcast_alu_slice #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       vector,
    input  logic             vec_valid,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int              IW     = $clog2(WIDTH);
    localparam logic [IW-1:0]   C_LAST = IW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_SLTU = 3'd6;
    localparam logic [2:0] OP_SEQ  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [IW-1:0]      r_idx;
    logic               r_carry;
    logic               r_lt;
    logic               r_eq;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_done;
    logic               r_ready;

    logic               w_ai;
    logic               w_bi;
    logic               w_last;
    logic [1:0]         w_pair;
    logic               w_match;
    logic               w_bit;
    logic               w_carry_nxt;
    logic               w_lt_nxt;
    logic               w_eq_nxt;
    logic [WIDTH-1:0]   w_res_nxt;
    logic [WIDTH-1:0]   w_result_fin;
    logic               w_cout_fin;
    logic               w_unused_x;

    assign w_unused_x = vector[5];

    always_comb begin
        w_state_nxt  = r_state;
        w_ai         = r_a[r_idx];
        w_bi         = r_b[r_idx];
        w_last       = (r_idx == C_LAST);
        w_pair       = {w_ai, w_bi ^ (r_op == OP_SUB)};
        // Signed compare: swapping the sign bits turns "a<b" into LT of the swapped pair
        if (r_op == OP_SLT && w_last) begin
            w_pair = {w_bi, w_ai};
        end
        w_match      = (r_state == S_RUN) && vec_valid && (vector[7:6] == w_pair);
        w_carry_nxt  = r_carry ? vector[4] : vector[1];
        w_lt_nxt     = vector[3] ? r_lt : vector[0];
        w_eq_nxt     = r_eq & vector[3];

        case (r_op)
            OP_ADD, OP_SUB: w_bit = r_carry ? vector[3] : vector[2];
            OP_AND:         w_bit = vector[1];
            OP_OR:          w_bit = vector[4];
            OP_XOR:         w_bit = vector[2];
            default:        w_bit = 1'b0;
        endcase

        w_res_nxt        = r_res;
        w_res_nxt[r_idx] = w_bit;

        case (r_op)
            OP_SLT, OP_SLTU: w_result_fin = {{(WIDTH-1){1'b0}}, w_lt_nxt};
            OP_SEQ:          w_result_fin = {{(WIDTH-1){1'b0}}, w_eq_nxt};
            default:         w_result_fin = w_res_nxt;
        endcase
        w_cout_fin = ((r_op == OP_ADD) || (r_op == OP_SUB)) && w_carry_nxt;

        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_match && w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_res       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_RUN) && (w_state_nxt == S_DONE);
            r_ready <= (w_state_nxt == S_IDLE);
            if (r_state == S_IDLE && start) begin
                r_a     <= a;
                r_b     <= b;
                r_op    <= op;
                r_idx   <= '0;
                r_carry <= (op == OP_SUB);
                r_lt    <= 1'b0;
                r_eq    <= 1'b1;
                r_res   <= '0;
            end else if (w_match) begin
                r_res   <= w_res_nxt;
                r_carry <= w_carry_nxt;
                r_lt    <= w_lt_nxt;
                r_eq    <= w_eq_nxt;
                if (w_last) begin
                    r_idx       <= '0;
                    r_result    <= w_result_fin;
                    r_carry_out <= w_cout_fin;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

    assign ready     = r_ready;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_broadcast_alu_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_broadcast_alu_slice
// Brief    : Self-checking bench: directed table, corner sequences, random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_broadcast_alu_slice;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   vector = 8'h00;
    logic         vec_valid = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

    int errors = 0;
    int checks = 0;

    logic [1:0] row = 2'd0;
    bit         vv_force = 1'b1;
    bit         vv_rand  = 1'b0;

    broadcast_alu_slice #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .vector    (vector),
        .vec_valid (vec_valid),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Truth table of a 1-bit full/compare cell for inputs (A,B)
    function automatic logic [7:0] mkvec(input logic [1:0] r);
        logic x, y;
        x = r[1];
        y = r[0];
        return {x, y, 1'b0, x | y, ~(x ^ y), x ^ y, x & y, ~x & y};
    endfunction

    // Vector cycler: rows 00,01,10,11 repeatedly
    always begin
        @(negedge clk);
        row       = row + 2'd1;
        vector    = mkvec(row);
        vec_valid = vv_rand ? 1'($urandom_range(0, 1)) : vv_force;
    end

    function automatic logic [8:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0: return {1'b0, x} + {1'b0, y};
            3'd1: return {(x >= y), 8'(x - y)};
            3'd2: return {1'b0, x & y};
            3'd3: return {1'b0, x | y};
            3'd4: return {1'b0, x ^ y};
            3'd5: return {1'b0, 7'd0, ($signed(x) < $signed(y))};
            3'd6: return {1'b0, 7'd0, (x < y)};
            default: return {1'b0, 7'd0, (x == y)};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_check(input string nm, input logic [2:0] o, input logic [7:0] x,
                             input logic [7:0] y, input logic [7:0] er, input logic ec,
                             input bit chk_lat);
        int  cyc;
        bit  got;
        logic rdy_run;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rdy_run = ready;
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_busy"}, 32'(rdy_run), 32'd0);
        chk({nm, "_result"}, 32'(result), 32'(er));
        chk({nm, "_carry"}, 32'(carry_out), 32'(ec));
        if (chk_lat) chk({nm, "_latency_ok"}, 32'(cyc >= W && cyc <= 4 * W + 2), 32'd1);
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_ready_after"}, 32'(ready), 32'd1);
        chk({nm, "_result_held"}, 32'(result), 32'(er));
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int  busy_bad;
        int  stray_done;
        bit  got;
        logic [8:0] m;

        tbl[0] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1};
        tbl[1] = '{3'd1, 8'h05, 8'h07, 8'hFE, 1'b0};
        tbl[2] = '{3'd1, 8'h07, 8'h05, 8'h02, 1'b1};
        tbl[3] = '{3'd2, 8'hA5, 8'h3C, 8'h24, 1'b0};
        tbl[4] = '{3'd3, 8'hA5, 8'h3C, 8'hBD, 1'b0};
        tbl[5] = '{3'd4, 8'hA5, 8'h3C, 8'h99, 1'b0};
        tbl[6] = '{3'd6, 8'h80, 8'h01, 8'h00, 1'b0};
        tbl[7] = '{3'd5, 8'h80, 8'h01, 8'h01, 1'b0};
        tbl[8] = '{3'd7, 8'h5A, 8'h5A, 8'h01, 1'b0};
        tbl[9] = '{3'd7, 8'h5A, 8'h5B, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_carry", 32'(carry_out), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].c, 1'b1);
        end

        // Stall mid-ADD with a stray start pulsed while busy
        @(negedge clk);
        op = 3'd0; a = 8'h12; b = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        vv_force = 1'b0;
        busy_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready || done) busy_bad++;
            if (i == 5) begin
                op = 3'd1; a = 8'hFF; b = 8'h0F; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        vv_force = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (ready) busy_bad++;
            @(negedge clk);
        end
        chk("stall_done_seen", 32'(got), 32'd1);
        chk("stall_busy", 32'(busy_bad), 32'd0);
        chk("stall_result", 32'(result), 32'h46);
        chk("stall_carry", 32'(carry_out), 32'd0);
        stray_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) stray_done++;
        end
        chk("stray_start_ignored", 32'(stray_done), 32'd0);
        chk("stray_result_held", 32'(result), 32'h46);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        op = 3'd0; a = 8'h77; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        stray_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) stray_done++;
        end
        chk("midrst_no_done", 32'(stray_done), 32'd0);
        run_check("after_rst_add", 3'd0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b1);

        // Random operations against the arithmetic model, then with a flickering vec_valid
        for (int i = 0; i < 40; i++) begin
            logic [2:0] ro;
            logic [7:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = (i % 5 == 0) ? ra : 8'($urandom);
            m  = model(ro, ra, rb);
            if (i >= 20) vv_rand = 1'b1;
            run_check($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, m[7:0], m[8], !vv_rand);
        end
        vv_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
